// File: rtl/nvr_host_if.sv
// -----------------------------------------------------------------------------
// nvr_host_if
// Request/response channel between the core's NVR port (master) and the
// nvr_host_ctrl access controller (slave).
//
// Handshake: a command transfers on a rising clk edge where req_valid and
// req_ready are both high. The master holds req_op/req_addr/req_wdata stable
// while req_valid is high. The slave never accepts a new command until the
// previous one has produced its single-cycle rsp_valid strobe. rsp_rdata and
// rsp_err are meaningful only in the cycle rsp_valid is high.
//
// Signals:
//   req_valid  master->slave  command valid
//   req_ready  slave->master  controller can accept a command
//   req_op     master->slave  00 read, 01 write, 10 store, 11 recall
//   req_addr   master->slave  word address (read/write)
//   req_wdata  master->slave  write data (write)
//   rsp_valid  slave->master  one-cycle completion strobe
//   rsp_rdata  slave->master  read data (reads), else 0
//   rsp_err    slave->master  RDY timeout flag
// -----------------------------------------------------------------------------
interface nvr_host_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/nvr_host_ctrl.sv
// -----------------------------------------------------------------------------
// nvr_host_ctrl
// Host-side access controller for the 128x32 non-volatile RAM macro.
// Accepts read/write/store/recall commands on the req channel, drives the
// macro pins through SETUP -> STROBE -> HOLD -> WAIT and returns a one-cycle
// response carrying read data or a RDY timeout error.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   req            nvr_host_if slave modport (request/response channel)
//   nvr_a/nvr_din  macro address / write data (held between commands)
//   nvr_ce/we/hs/hr macro chip enable, write enable, store, recall
//   nvr_dout       macro read data
//   nvr_rdy        macro ready, asynchronous to clk
//   dbg_state_o    current FSM state encoding
// -----------------------------------------------------------------------------
module nvr_host_ctrl #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 32,
   parameter int STROBE_CYC = 2,
   parameter int TIMEOUT    = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   nvr_host_if.slave         req,
   output logic [ADDR_W-1:0] nvr_a,
   output logic [DATA_W-1:0] nvr_din,
   output logic              nvr_ce,
   output logic              nvr_we,
   output logic              nvr_hs,
   output logic              nvr_hr,
   input  logic [DATA_W-1:0] nvr_dout,
   input  logic              nvr_rdy,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4,
      S_WAIT   = 3'd5,
      S_RESP   = 3'd6
   } state_t;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_STORE  = 2'b10;
   localparam logic [1:0] OP_RECALL = 2'b11;

   // One counter serves the strobe width, the hold window and the RDY
   // timeout; it restarts on STROBE entry and saturates.
   localparam int CNT_MAX = (TIMEOUT > STROBE_CYC + 1) ? TIMEOUT : STROBE_CYC + 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_TO    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(STROBE_CYC + 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              init_err_q, init_err_d;
   logic              rdy_s1_q, rdy_s_q;

   // State register, synchronizer and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_INIT;
         cnt_q      <= '0;
         op_q       <= OP_READ;
         a_q        <= '0;
         din_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         init_err_q <= 1'b0;
         rdy_s1_q   <= 1'b0;
         rdy_s_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         din_q      <= din_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         init_err_q <= init_err_d;
         rdy_s1_q   <= nvr_rdy;
         rdy_s_q    <= rdy_s1_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q < CNT_SAT) ? cnt_q + 1'b1 : cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      din_d      = din_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      init_err_d = init_err_q;
      case (state_q)
         S_INIT: begin
            if (rdy_s_q) begin
               state_d = S_IDLE;
            end else if (cnt_q >= CNT_TO) begin
               state_d    = S_IDLE;
               init_err_d = 1'b1;
            end
         end
         S_IDLE: begin
            if (req.req_valid) begin
               state_d = S_SETUP;
               op_d    = req.req_op;
               // Store/recall act on the whole array; address pins parked at 0.
               a_d     = req.req_op[1] ? '0 : req.req_addr;
               din_d   = req.req_wdata;
               err_d   = 1'b0;
            end
         end
         S_SETUP: begin
            state_d = S_STROBE;
            cnt_d   = '0;
         end
         S_STROBE: begin
            if (cnt_q >= STB_LAST) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (cnt_q >= HOLD_LAST) state_d = S_WAIT;
         end
         S_WAIT: begin
            // A genuine RDY wins over a timeout in the same cycle.
            if (rdy_s_q) begin
               state_d = S_RESP;
               if (op_q == OP_READ) rdata_d = nvr_dout;
            end else if (cnt_q >= CNT_TO) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end
         end
         S_RESP: begin
            state_d    = S_IDLE;
            init_err_d = 1'b0;
         end
         default: state_d = S_INIT;
      endcase
   end

   // Output decode
   always_comb begin
      req.req_ready = (state_q == S_IDLE);
      req.rsp_valid = (state_q == S_RESP);
      req.rsp_rdata = ((state_q == S_RESP) && (op_q == OP_READ)) ? rdata_q : '0;
      req.rsp_err   = (state_q == S_RESP) && (err_q || init_err_q);
      nvr_ce        = (state_q == S_STROBE) && !op_q[1];
      nvr_we        = (state_q == S_STROBE) && (op_q == OP_WRITE);
      nvr_hs        = (state_q == S_STROBE) && (op_q == OP_STORE);
      nvr_hr        = (state_q == S_STROBE) && (op_q == OP_RECALL);
      nvr_a         = a_q;
      nvr_din       = din_q;
      dbg_state_o   = state_q;
   end

endmodule
